// File: rtl/edge_pkg.sv
// Shared definitions for the edge-filter pipeline: scheduler state encoding
// and the tile width shared with the blur controller.
package edge_pkg;

  localparam int unsigned TILE_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_MOVE    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_DONE    = 3'd5
  } anchor_state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear; returns to zero after reaching
// rollover_val. rollover_flag is decoded from the count register.
module flex_counter #(
  parameter int NUM_CNT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= rollover_flag ? '0 : count_out + 1'b1;
    end
  end

  assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/anchor_sequencer.sv
// Frame scheduler: walks the anchor down 16-pixel column strips and sequences
// each tile through load, move and blur. Optional macro ANCHOR_SEQ_PAUSE_EN.
module anchor_sequencer
  import edge_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        abort,
`ifdef ANCHOR_SEQ_PAUSE_EN
  input  logic        pause,
`endif
  output logic        load_req,
  input  logic        load_done,
  output logic        anchor_moving,
  output logic [31:0] anchor_x,
  output logic [31:0] anchor_y,
  output logic        first_row,
  input  logic        blur_final,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [31:0] ROW_LAST = 32'(IMG_H - 1);
  localparam logic [31:0] COL_LAST = 32'(IMG_W - TILE_W);

  anchor_state_t state, next_state;
  logic          hold;
  logic          frame_start;
  logic          advance_go;
  logic          row_wrap;
  logic          last_tile;

`ifdef ANCHOR_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign frame_start = (state == ST_IDLE) && start && !abort;
  assign advance_go  = (state == ST_ADVANCE) && !hold && !abort;
  assign last_tile   = row_wrap && !(anchor_x < COL_LAST);

  // The last tile must not bump the row counter so coordinates survive DONE.
  flex_counter #(.NUM_CNT_BITS(32)) u_row_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (frame_start || abort),
    .count_enable (advance_go && !last_tile),
    .rollover_val (ROW_LAST),
    .count_out    (anchor_y),
    .rollover_flag(row_wrap)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      anchor_x <= '0;
    end else if (abort || frame_start) begin
      anchor_x <= '0;
    end else if (advance_go && row_wrap && !last_tile) begin
      anchor_x <= anchor_x + 32'(TILE_W);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    if (start) next_state = ST_LOAD;
        ST_LOAD:    if (load_done) next_state = ST_MOVE;
        ST_MOVE:    next_state = ST_WAIT;
        ST_WAIT:    if (blur_final) next_state = ST_ADVANCE;
        ST_ADVANCE: if (!hold) next_state = last_tile ? ST_DONE : ST_LOAD;
        ST_DONE:    next_state = ST_IDLE;
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  assign load_req      = (state == ST_LOAD);
  assign anchor_moving = (state == ST_MOVE);
  assign busy          = (state != ST_IDLE);
  assign frame_done    = (state == ST_DONE);
  assign first_row     = (anchor_y == '0);

endmodule

// File: tb/tb_anchor_sequencer.sv
// Scoreboard bench: a 32x3 frame instance and a 16x1 single-tile instance;
// expected anchor pulses and frame_done markers are queued and popped by monitors.
module tb_anchor_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;

  logic        s_start, s_abort, s_pause, s_load_done, s_blur_final;
  logic        s_load_req, s_anchor_moving, s_first_row, s_busy, s_frame_done;
  logic [31:0] s_anchor_x, s_anchor_y;

  logic        t_start, t_abort, t_load_done, t_blur_final;
  logic        t_load_req, t_anchor_moving, t_first_row, t_busy, t_frame_done;
  logic [31:0] t_anchor_x, t_anchor_y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          done;
    logic [31:0] x;
    logic [31:0] y;
  } exp_t;

  exp_t s_q[$];
  exp_t t_q[$];

  anchor_sequencer #(.IMG_W(32), .IMG_H(3)) u_small (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (s_start),
    .abort        (s_abort),
`ifdef ANCHOR_SEQ_PAUSE_EN
    .pause        (s_pause),
`endif
    .load_req     (s_load_req),
    .load_done    (s_load_done),
    .anchor_moving(s_anchor_moving),
    .anchor_x     (s_anchor_x),
    .anchor_y     (s_anchor_y),
    .first_row    (s_first_row),
    .blur_final   (s_blur_final),
    .busy         (s_busy),
    .frame_done   (s_frame_done)
  );

  anchor_sequencer #(.IMG_W(16), .IMG_H(1)) u_single (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (t_start),
    .abort        (t_abort),
`ifdef ANCHOR_SEQ_PAUSE_EN
    .pause        (1'b0),
`endif
    .load_req     (t_load_req),
    .load_done    (t_load_done),
    .anchor_moving(t_anchor_moving),
    .anchor_x     (t_anchor_x),
    .anchor_y     (t_anchor_y),
    .first_row    (t_first_row),
    .blur_final   (t_blur_final),
    .busy         (t_busy),
    .frame_done   (t_frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic exp_t mk(input bit done, input int x, input int y);
    exp_t e;
    e.done = done;
    e.x    = 32'(x);
    e.y    = 32'(y);
    return e;
  endfunction

  // Monitors: pop an expectation whenever a DUT presents a pulse.
  always @(negedge clk) begin
    if (n_rst && (s_anchor_moving || s_frame_done)) begin
      if (s_q.size() == 0) begin
        check("s_unexpected_event", 32'(s_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = s_q.pop_front();
        check("s_event_kind", 32'(s_frame_done), 32'(e.done));
        if (!e.done) begin
          check("s_anchor_x", s_anchor_x, e.x);
          check("s_anchor_y", s_anchor_y, e.y);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst && (t_anchor_moving || t_frame_done)) begin
      if (t_q.size() == 0) begin
        check("t_unexpected_event", 32'(t_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = t_q.pop_front();
        check("t_event_kind", 32'(t_frame_done), 32'(e.done));
        if (!e.done) begin
          check("t_anchor_x", t_anchor_x, e.x);
          check("t_anchor_y", t_anchor_y, e.y);
        end
      end
    end
  end

  task automatic s_wait_load();
    int k = 0;
    while (!s_load_req && k < 50) begin
      tick();
      k++;
    end
    check("s_load_req_timeout", 32'(s_load_req), 32'd1);
  endtask

  // Runs one tile from LOAD to the ADVANCE cycle; loader and blur answer late.
  task automatic s_tile(input bit stray, input bit do_pause);
    s_wait_load();
    tick();
    if (stray) begin
      s_blur_final = 1'b1;
      tick();
      s_blur_final = 1'b0;
      check("stray_blur_in_load", 32'({s_load_req, s_anchor_moving}), 32'b10);
    end else begin
      tick();
    end
    s_load_done = 1'b1;
    tick();
    s_load_done = 1'b0;
    tick();
    if (stray) begin
      s_load_done = 1'b1;
      tick();
      s_load_done = 1'b0;
      check("stray_load_in_wait", 32'({s_load_req, s_anchor_moving, s_busy}), 32'b001);
    end else begin
      tick();
    end
    tick();
    s_blur_final = 1'b1;
    s_pause      = do_pause;
    tick();
    s_blur_final = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    s_start = 0; s_abort = 0; s_pause = 0; s_load_done = 0; s_blur_final = 0;
    t_start = 0; t_abort = 0; t_load_done = 0; t_blur_final = 0;
    n_rst = 1'b0;
    tick(3);
    check("rst_load_req", 32'(s_load_req), 32'd0);
    check("rst_anchor_moving", 32'(s_anchor_moving), 32'd0);
    check("rst_anchor_x", s_anchor_x, 32'd0);
    check("rst_anchor_y", s_anchor_y, 32'd0);
    check("rst_first_row", 32'(s_first_row), 32'd1);
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_frame_done", 32'(s_frame_done), 32'd0);
    n_rst = 1'b1;
    tick();

    // Full 32x3 frame, strays injected on the second tile.
    s_q.push_back(mk(0, 0, 0));  s_q.push_back(mk(0, 0, 1));
    s_q.push_back(mk(0, 0, 2));  s_q.push_back(mk(0, 16, 0));
    s_q.push_back(mk(0, 16, 1)); s_q.push_back(mk(0, 16, 2));
    s_q.push_back(mk(1, 0, 0));
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("start_load_req", 32'(s_load_req), 32'd1);
    check("start_busy", 32'(s_busy), 32'd1);
    for (int i = 0; i < 6; i++) s_tile(i == 1, 1'b0);
    tick();
    check("frame_done_pulse", 32'(s_frame_done), 32'd1);
    tick();
    check("idle_after_done", 32'(s_busy), 32'd0);
    check("held_anchor_x", s_anchor_x, 32'd16);
    check("held_anchor_y", s_anchor_y, 32'd2);
    check("frame_events_left", 32'(s_q.size()), 32'd0);

    // Abort in WAIT at tile (16,1).
    s_q.push_back(mk(0, 0, 0));  s_q.push_back(mk(0, 0, 1));
    s_q.push_back(mk(0, 0, 2));  s_q.push_back(mk(0, 16, 0));
    s_q.push_back(mk(0, 16, 1));
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) s_tile(1'b0, 1'b0);
    s_wait_load();
    s_load_done = 1'b1;
    tick();
    s_load_done = 1'b0;
    tick();
    check("abort_pre_x", s_anchor_x, 32'd16);
    check("abort_pre_y", s_anchor_y, 32'd1);
    s_abort = 1'b1;
    tick();
    s_abort = 1'b0;
    check("abort_busy", 32'(s_busy), 32'd0);
    check("abort_x", s_anchor_x, 32'd0);
    check("abort_y", s_anchor_y, 32'd0);
    check("abort_load_req", 32'(s_load_req), 32'd0);
    tick(3);
    check("abort_events_left", 32'(s_q.size()), 32'd0);
    s_start = 1'b1;
    s_abort = 1'b1;
    tick(2);
    check("start_with_abort", 32'({s_busy, s_load_req}), 32'd0);
    s_start = 1'b0;
    s_abort = 1'b0;

`ifdef ANCHOR_SEQ_PAUSE_EN
    s_q.push_back(mk(0, 0, 0));
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_tile(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("pause_hold_y", s_anchor_y, 32'd0);
      check("pause_hold_load_req", 32'(s_load_req), 32'd0);
      if (i < 4) tick();
    end
    s_pause = 1'b0;
    tick();
    check("pause_resume_y", s_anchor_y, 32'd1);
    check("pause_resume_load_req", 32'(s_load_req), 32'd1);
    s_abort = 1'b1;
    tick();
    s_abort = 1'b0;
    check("pause_abort_busy", 32'(s_busy), 32'd0);
    check("pause_events_left", 32'(s_q.size()), 32'd0);
`endif

    // Single-tile frame: DONE four edges after load_done is sampled.
    t_q.push_back(mk(0, 0, 0));
    t_q.push_back(mk(1, 0, 0));
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    check("single_load_req", 32'(t_load_req), 32'd1);
    t_load_done = 1'b1;
    tick();
    t_load_done = 1'b0;
    check("single_move", 32'(t_anchor_moving), 32'd1);
    tick();
    check("single_wait", 32'({t_busy, t_anchor_moving, t_load_req}), 32'b100);
    t_blur_final = 1'b1;
    tick();
    t_blur_final = 1'b0;
    check("single_advance_no_done", 32'(t_frame_done), 32'd0);
    tick();
    check("single_frame_done", 32'(t_frame_done), 32'd1);
    tick();
    check("single_idle", 32'(t_busy), 32'd0);
    check("single_events_left", 32'(t_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
